conv2_window_buf: RTL and testbench
===================================

# conv2_window_buf

Line-buffer front end for the 2nd convolution layer. It accepts the pooled layer-1 feature map as a raster-order pixel stream, one pixel per valid cycle. It emits every complete 5×5 window as 25 parallel pixels with a one-cycle strobe. It drives the `valid_out_buf` / `data_out_0..24` interface consumed by the conv2 convolution-sum stage.

## Interface
- `WIDTH`, 12: feature-map columns (≥5)
- `HEIGHT`, 12: feature-map rows (≥5)
- `DATA_BITS`, 12: pixel width
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  synchronous reset, active-high
- `valid_in`  in  1  `data_in` carries a pixel this cycle
- `data_in`  in  `DATA_BITS`  pixel, raster order (row-major, column 0 first)
- `data_out_0` … `data_out_24`  out  `DATA_BITS` each  window pixels; index k = row k/5, column k%5; `data_out_0` top-left (oldest), `data_out_24` bottom-right (newest)
- `valid_out_buf`  out  1  window on `data_out_*` is complete and valid for exactly this cycle
- `frame_done`  out  1  present only with `CONV2_BUF_FRAME_DONE_EN` (see Configuration)

## Operation
- Storage: shift register of depth 4·`WIDTH`+5 pixels (`buf[0]` newest).
- On each cycle with `valid_in`=1:
  - shift `data_in` in; contents advance one position.
  - advance `col` (0..`WIDTH`-1) and `row` (0..`HEIGHT`-1) counters.
  - `col` wraps to 0 and increments `row`.
  - after `col`=`WIDTH`-1 and `row`=`HEIGHT`-1, both wrap to 0: next pixel starts a new frame.
- No back-pressure. The consumer accepts every window; the upstream never stalls.
- Window tap mapping: `data_out_k` = `buf[(4 − k/5)·WIDTH + (4 − k%5)]`. These are direct wiring from the shift register, so the outputs are registered.
- Window validity: `valid_out_buf` is registered.
  - It is set to 1 on the edge that accepts a pixel at (`row`≥4, `col`≥4), using counter values before the increment.
  - Otherwise it is 0.
- Windows per frame: (`HEIGHT`−4)·(`WIDTH`−4); 64 at defaults.
- Row-straddling windows (`col`<4) are never flagged valid.
- `valid_in`=0: shift register, counters and `data_out_*` hold; `valid_out_buf` drops to 0 on that edge.
- Frames stream back-to-back with no bubble required. Rows 0–3 of a new frame produce no valid windows even though the buffer still holds the previous frame.

## Timing
- Reset (`rst`=1 at an edge), including mid-frame:
  - shift register, `row`, `col`, `valid_out_buf` and `frame_done` all go to 0.
  - every `data_out_*` reads 0 after that edge.
  - the next accepted pixel is frame pixel (0,0).
- Reset has priority over `valid_in` on the same edge; that pixel is dropped.
- Latency: a window is visible one cycle after the edge that accepts its bottom-right pixel. `valid_out_buf` is high in that same cycle.
- Throughput: one window per cycle during contiguous valid input within columns 4..`WIDTH`-1.
- `valid_out_buf` is never high for two cycles on the same window. A stall after a valid window drops the strobe while `data_out_*` hold their values.

## Configuration
- `CONV2_BUF_FRAME_DONE_EN` defined:
  - adds a 1-bit output `frame_done`, reset 0.
  - `frame_done` is registered and pulses for one cycle, coincident with `valid_out_buf`, for the window whose bottom-right pixel is (`HEIGHT`−1, `WIDTH`−1).
- Undefined: the `frame_done` port and its logic are absent; all other behaviour is identical.

## Test plan
- Single frame, `valid_in` held high, `data_in` = pixel index p (0..143):
  - first `valid_out_buf` occurs in the cycle after p=52, with `data_out_0`=0, `data_out_4`=4, `data_out_20`=48, `data_out_24`=52.
  - exactly 64 strobes in total.
  - no strobe after p=60..63 (cols 0..3 of row 5).
- Same stream with `valid_in` low for 3 cycles after p=53:
  - strobe for p=53 lasts one cycle, then stays 0 for 3 cycles.
  - `data_out_24` holds at 53.
  - next strobe shows `data_out_24`=54, `data_out_0`=2.
- Two back-to-back frames, second with `data_in` = p+1000:
  - 128 strobes in total.
  - first strobe of frame 2 follows pixel 1052, with `data_out_0`=1000.
  - no strobe during frame-2 rows 0–3.
- Reset pulsed for one cycle at p=70 while `valid_in`=1:
  - next cycle `valid_out_buf`=0 and all `data_out_*`=0.
  - a fresh frame then produces its first strobe after its 53rd accepted pixel.
- With `CONV2_BUF_FRAME_DONE_EN`:
  - `frame_done`=1 only in the cycle after p=143, together with `valid_out_buf`=1 and `data_out_24`=143, `data_out_0`=91.
  - `frame_done` stays 0 for all other 63 windows.

Source files
------------

// File: rtl/conv2_window_buf_if.sv
// Pixel-stream in / 5x5 window out bundle between the pooled layer-1 stream and the conv2 sum stage.
// Optional frame_done strobe is present only when CONV2_BUF_FRAME_DONE_EN is defined.
interface conv2_window_buf_if #(
  parameter int DATA_BITS = 12
);
  logic                 valid_in;
  logic [DATA_BITS-1:0] data_in;
  logic                 valid_out_buf;
  logic [DATA_BITS-1:0] data_out_0,  data_out_1,  data_out_2,  data_out_3,  data_out_4;
  logic [DATA_BITS-1:0] data_out_5,  data_out_6,  data_out_7,  data_out_8,  data_out_9;
  logic [DATA_BITS-1:0] data_out_10, data_out_11, data_out_12, data_out_13, data_out_14;
  logic [DATA_BITS-1:0] data_out_15, data_out_16, data_out_17, data_out_18, data_out_19;
  logic [DATA_BITS-1:0] data_out_20, data_out_21, data_out_22, data_out_23, data_out_24;
`ifdef CONV2_BUF_FRAME_DONE_EN
  logic                 frame_done;
`endif

  modport slave (
    input  valid_in,
    input  data_in,
`ifdef CONV2_BUF_FRAME_DONE_EN
    output frame_done,
`endif
    output valid_out_buf,
    output data_out_0,  data_out_1,  data_out_2,  data_out_3,  data_out_4,
    output data_out_5,  data_out_6,  data_out_7,  data_out_8,  data_out_9,
    output data_out_10, data_out_11, data_out_12, data_out_13, data_out_14,
    output data_out_15, data_out_16, data_out_17, data_out_18, data_out_19,
    output data_out_20, data_out_21, data_out_22, data_out_23, data_out_24
  );

  modport master (
    output valid_in,
    output data_in,
`ifdef CONV2_BUF_FRAME_DONE_EN
    input  frame_done,
`endif
    input  valid_out_buf,
    input  data_out_0,  data_out_1,  data_out_2,  data_out_3,  data_out_4,
    input  data_out_5,  data_out_6,  data_out_7,  data_out_8,  data_out_9,
    input  data_out_10, data_out_11, data_out_12, data_out_13, data_out_14,
    input  data_out_15, data_out_16, data_out_17, data_out_18, data_out_19,
    input  data_out_20, data_out_21, data_out_22, data_out_23, data_out_24
  );
endinterface

// File: rtl/conv2_window_buf.sv
// Line buffer for conv2: raster pixel stream in, every complete 5x5 window out with a one-cycle strobe.
// Defining CONV2_BUF_FRAME_DONE_EN adds a frame_done pulse on the last window of each frame.
module conv2_window_buf #(
  parameter int WIDTH     = 12,
  parameter int HEIGHT    = 12,
  parameter int DATA_BITS = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  conv2_window_buf_if.slave        bus
);
  localparam int DEPTH = 4 * WIDTH + 5;
  localparam int CW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(4);
  localparam logic [RW-1:0] ROW_MIN  = RW'(4);

  logic [DATA_BITS-1:0] sr_q [DEPTH];
  logic [DATA_BITS-1:0] sr_d [DEPTH];
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;

  always_comb begin
    sr_d    = sr_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (bus.valid_in) begin
      sr_d[0] = bus.data_in;
      for (int i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
      // Window judged on the position of the pixel being accepted, before the counters move.
      valid_d = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
      done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.valid_out_buf = valid_q;

`ifdef CONV2_BUF_FRAME_DONE_EN
  assign bus.frame_done = done_q;
`else
  logic unused_done;
  assign unused_done = done_q;
`endif

  // Tap k sits at row k/5, column k%5 of the window; sr_q[0] is the bottom-right (newest) pixel.
  assign bus.data_out_0  = sr_q[4*WIDTH + 4];
  assign bus.data_out_1  = sr_q[4*WIDTH + 3];
  assign bus.data_out_2  = sr_q[4*WIDTH + 2];
  assign bus.data_out_3  = sr_q[4*WIDTH + 1];
  assign bus.data_out_4  = sr_q[4*WIDTH + 0];
  assign bus.data_out_5  = sr_q[3*WIDTH + 4];
  assign bus.data_out_6  = sr_q[3*WIDTH + 3];
  assign bus.data_out_7  = sr_q[3*WIDTH + 2];
  assign bus.data_out_8  = sr_q[3*WIDTH + 1];
  assign bus.data_out_9  = sr_q[3*WIDTH + 0];
  assign bus.data_out_10 = sr_q[2*WIDTH + 4];
  assign bus.data_out_11 = sr_q[2*WIDTH + 3];
  assign bus.data_out_12 = sr_q[2*WIDTH + 2];
  assign bus.data_out_13 = sr_q[2*WIDTH + 1];
  assign bus.data_out_14 = sr_q[2*WIDTH + 0];
  assign bus.data_out_15 = sr_q[1*WIDTH + 4];
  assign bus.data_out_16 = sr_q[1*WIDTH + 3];
  assign bus.data_out_17 = sr_q[1*WIDTH + 2];
  assign bus.data_out_18 = sr_q[1*WIDTH + 1];
  assign bus.data_out_19 = sr_q[1*WIDTH + 0];
  assign bus.data_out_20 = sr_q[4];
  assign bus.data_out_21 = sr_q[3];
  assign bus.data_out_22 = sr_q[2];
  assign bus.data_out_23 = sr_q[1];
  assign bus.data_out_24 = sr_q[0];
endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf at 12x12, 12-bit pixels; pixel values encode their raster index.
// Build with CONV2_BUF_FRAME_DONE_EN defined to also exercise frame_done.
module tb_conv2_window_buf;
  localparam int W = 12;
  localparam int H = 12;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  conv2_window_buf_if #(.DATA_BITS(12)) bus ();

  conv2_window_buf #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [11:0] dout [25];
  assign dout[0]  = bus.data_out_0;
  assign dout[1]  = bus.data_out_1;
  assign dout[2]  = bus.data_out_2;
  assign dout[3]  = bus.data_out_3;
  assign dout[4]  = bus.data_out_4;
  assign dout[5]  = bus.data_out_5;
  assign dout[6]  = bus.data_out_6;
  assign dout[7]  = bus.data_out_7;
  assign dout[8]  = bus.data_out_8;
  assign dout[9]  = bus.data_out_9;
  assign dout[10] = bus.data_out_10;
  assign dout[11] = bus.data_out_11;
  assign dout[12] = bus.data_out_12;
  assign dout[13] = bus.data_out_13;
  assign dout[14] = bus.data_out_14;
  assign dout[15] = bus.data_out_15;
  assign dout[16] = bus.data_out_16;
  assign dout[17] = bus.data_out_17;
  assign dout[18] = bus.data_out_18;
  assign dout[19] = bus.data_out_19;
  assign dout[20] = bus.data_out_20;
  assign dout[21] = bus.data_out_21;
  assign dout[22] = bus.data_out_22;
  assign dout[23] = bus.data_out_23;
  assign dout[24] = bus.data_out_24;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input, then sample just after the edge that consumes it.
  task automatic step(input logic v, input logic [11:0] d);
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 12'd0);
    rst = 1'b0;
  endtask

  // Expected window pixel k for the window whose bottom-right pixel is (r,c), pixels valued base+index.
  function automatic logic [11:0] exp_pix(input int r, input int c, input int k, input int base);
    return 12'(base + (r - 4 + k / 5) * W + (c - 4 + k % 5));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 12'd77);
    rst = 1'b0;
    vectors++;
    if (bus.valid_out_buf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b want 0", bus.valid_out_buf);
    end
    for (int k = 0; k < 25; k++) begin
      vectors++;
      if (dout[k] !== 12'd0) begin
        miscompares++;
        $display("FAIL reset_data_out_%0d: got %0d want 0", k, dout[k]);
      end
    end
  endtask

  task automatic test_single_frame();
    int strobes;
    strobes = 0;
    do_reset();
    for (int p = 0; p < W * H; p++) begin
      logic ev;
      step(1'b1, 12'(p));
      ev = (p / W >= 4) && (p % W >= 4);
      vectors++;
      if (bus.valid_out_buf !== ev) begin
        miscompares++;
        $display("FAIL single_valid p=%0d: got %b want %b", p, bus.valid_out_buf, ev);
      end
      if (ev) begin
        strobes++;
        for (int k = 0; k < 25; k++) begin
          vectors++;
          if (dout[k] !== exp_pix(p / W, p % W, k, 0)) begin
            miscompares++;
            $display("FAIL single_window p=%0d k=%0d: got %0d want %0d", p, k, dout[k],
                     exp_pix(p / W, p % W, k, 0));
          end
        end
      end
    end
    vectors++;
    if (strobes !== 64) begin
      miscompares++;
      $display("FAIL single_strobe_count: got %0d want 64", strobes);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int p = 0; p <= 53; p++) step(1'b1, 12'(p));
    vectors++;
    if (bus.valid_out_buf !== 1'b1 || dout[24] !== 12'd53 || dout[0] !== 12'd1) begin
      miscompares++;
      $display("FAIL stall_pre: valid=%b d24=%0d d0=%0d want 1/53/1", bus.valid_out_buf, dout[24], dout[0]);
    end
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 12'd999);
      vectors++;
      if (bus.valid_out_buf !== 1'b0 || dout[24] !== 12'd53 || dout[0] !== 12'd1) begin
        miscompares++;
        $display("FAIL stall_hold s=%0d: valid=%b d24=%0d d0=%0d want 0/53/1", s, bus.valid_out_buf,
                 dout[24], dout[0]);
      end
    end
    step(1'b1, 12'd54);
    vectors++;
    if (bus.valid_out_buf !== 1'b1 || dout[24] !== 12'd54 || dout[0] !== 12'd2) begin
      miscompares++;
      $display("FAIL stall_resume: valid=%b d24=%0d d0=%0d want 1/54/2", bus.valid_out_buf, dout[24], dout[0]);
    end
    step(1'b0, 12'd0);
    vectors++;
    if (bus.valid_out_buf !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_single_pulse: got %b want 0", bus.valid_out_buf);
    end
  endtask

  task automatic test_back_to_back();
    int strobes;
    strobes = 0;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < W * H; p++) begin
        logic ev;
        int   base;
        base = f * 1000;
        step(1'b1, 12'(base + p));
        ev = (p / W >= 4) && (p % W >= 4);
        vectors++;
        if (bus.valid_out_buf !== ev) begin
          miscompares++;
          $display("FAIL b2b_valid f=%0d p=%0d: got %b want %b", f, p, bus.valid_out_buf, ev);
        end
        if (ev) begin
          strobes++;
          vectors++;
          if (dout[0] !== exp_pix(p / W, p % W, 0, base) || dout[24] !== exp_pix(p / W, p % W, 24, base)) begin
            miscompares++;
            $display("FAIL b2b_window f=%0d p=%0d: d0=%0d d24=%0d want %0d/%0d", f, p, dout[0], dout[24],
                     exp_pix(p / W, p % W, 0, base), exp_pix(p / W, p % W, 24, base));
          end
        end
      end
    end
    vectors++;
    if (strobes !== 128) begin
      miscompares++;
      $display("FAIL b2b_strobe_count: got %0d want 128", strobes);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int p = 0; p < 70; p++) step(1'b1, 12'(p));
    rst = 1'b1;
    step(1'b1, 12'd70);
    rst = 1'b0;
    vectors++;
    if (bus.valid_out_buf !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_valid: got %b want 0", bus.valid_out_buf);
    end
    for (int k = 0; k < 25; k++) begin
      vectors++;
      if (dout[k] !== 12'd0) begin
        miscompares++;
        $display("FAIL midreset_data_out_%0d: got %0d want 0", k, dout[k]);
      end
    end
    for (int p = 0; p <= 53; p++) begin
      logic ev;
      step(1'b1, 12'(500 + p));
      ev = (p == 52) || (p == 53);
      vectors++;
      if (bus.valid_out_buf !== ev) begin
        miscompares++;
        $display("FAIL midreset_fresh_valid p=%0d: got %b want %b", p, bus.valid_out_buf, ev);
      end
    end
    vectors++;
    if (dout[24] !== 12'd553 || dout[0] !== 12'd501) begin
      miscompares++;
      $display("FAIL midreset_fresh_window: d24=%0d d0=%0d want 553/501", dout[24], dout[0]);
    end
  endtask

`ifdef CONV2_BUF_FRAME_DONE_EN
  task automatic test_frame_done();
    do_reset();
    for (int p = 0; p < W * H; p++) begin
      logic ed;
      step(1'b1, 12'(p));
      ed = (p == W * H - 1);
      vectors++;
      if (bus.frame_done !== ed) begin
        miscompares++;
        $display("FAIL frame_done p=%0d: got %b want %b", p, bus.frame_done, ed);
      end
    end
    vectors++;
    if (bus.valid_out_buf !== 1'b1 || dout[24] !== 12'd143 || dout[0] !== 12'd91) begin
      miscompares++;
      $display("FAIL frame_done_window: valid=%b d24=%0d d0=%0d want 1/143/91", bus.valid_out_buf,
               dout[24], dout[0]);
    end
    step(1'b1, 12'd0);
    vectors++;
    if (bus.frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_done_pulse: got %b want 0", bus.frame_done);
    end
  endtask
`endif

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef CONV2_BUF_FRAME_DONE_EN
    test_frame_done();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
